// File: rtl/l2_plru_pkg.sv
// Shared tree pseudo-LRU helpers: victim walk and touch update over a heap-ordered node vector.
// Functions are sized for the largest supported tree and trimmed by the caller.
package l2_plru_pkg;

  localparam int MAX_WAYS  = 64;
  localparam int MAX_NODES = MAX_WAYS - 1;
  localparam int MAX_WAY_W = 6;
  localparam int MAX_LVL   = 6;

  typedef logic [MAX_NODES-1:0] plru_tree_t;
  typedef logic [MAX_WAY_W-1:0] plru_way_t;
  typedef logic [MAX_WAY_W-1:0] plru_node_t;

  // Node bit 1 steers the victim into the lower half, so each step goes to ~bit.
  function automatic plru_way_t plru_victim(input plru_tree_t tree, input int num_ways);
    int         levels;
    plru_node_t node;
    plru_way_t  way;
    logic       dir;
    levels = $clog2(num_ways);
    node   = '0;
    way    = '0;
    dir    = 1'b0;
    for (int lvl = 0; lvl < MAX_LVL; lvl++) begin
      if (lvl < levels) begin
        dir  = ~tree[node];
        way  = {way[MAX_WAY_W-2:0], dir};
        node = {node[MAX_WAY_W-2:0], 1'b0} + plru_node_t'(1) + plru_node_t'(dir);
      end
    end
    return way;
  endfunction

  function automatic plru_tree_t plru_update(input plru_tree_t tree, input plru_way_t way,
                                             input int num_ways);
    plru_tree_t t;
    plru_node_t node;
    plru_way_t  sh;
    int         levels;
    logic       up;
    t      = tree;
    levels = $clog2(num_ways);
    node   = '0;
    sh     = '0;
    up     = 1'b0;
    for (int lvl = 0; lvl < MAX_LVL; lvl++) begin
      if (lvl < levels) begin
        sh      = way >> (levels - 1 - lvl);
        up      = sh[0];
        t[node] = up;
        node    = {node[MAX_WAY_W-2:0], 1'b0} + plru_node_t'(1) + plru_node_t'(up);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/l2_plru_tree_logic.sv
// Combinational PLRU datapath: victim selection (invalid ways first) for the lookup tree
// and next-state tree for a touched way.
module l2_plru_tree_logic
  import l2_plru_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int NODES    = NUM_WAYS - 1
) (
  input  logic [NODES-1:0]    look_tree_i,
  input  logic [NUM_WAYS-1:0] way_valid_i,
  output logic [WAY_W-1:0]    victim_o,
  input  logic [NODES-1:0]    upd_tree_i,
  input  logic [WAY_W-1:0]    upd_way_i,
  output logic [NODES-1:0]    upd_tree_o
);

  logic             any_inv;
  logic [WAY_W-1:0] inv_way;

  // Descending scan leaves the lowest-index invalid way as the winner.
  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    victim_o = any_inv ? inv_way
                       : WAY_W'(plru_victim(plru_tree_t'(look_tree_i), NUM_WAYS));
  end

  always_comb begin
    upd_tree_o = NODES'(plru_update(plru_tree_t'(upd_tree_i), plru_way_t'(upd_way_i), NUM_WAYS));
  end

endmodule

// File: rtl/l2_plru_tracker.sv
// Per-set tree PLRU state for the L2 with registered victim output, touch-to-lookup
// forwarding on the same set, and a single-cycle flush.
module l2_plru_tracker
  import l2_plru_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 32,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                lookup_valid,
  input  logic [SET_W-1:0]    lookup_set,
  input  logic [NUM_WAYS-1:0] way_valid,
  output logic                victim_valid,
  output logic [WAY_W-1:0]    victim_way,
  input  logic                touch_valid,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [WAY_W-1:0]    touch_way
);

  localparam int NODES = NUM_WAYS - 1;

  logic [NODES-1:0] tree_q [NUM_SETS];
  logic [NODES-1:0] touch_tree;
  logic [NODES-1:0] touch_tree_next;
  logic [NODES-1:0] look_tree;
  logic             fwd;
  logic [WAY_W-1:0] victim_way_d;
  logic             victim_valid_q;
  logic [WAY_W-1:0] victim_way_q;

  assign touch_tree = tree_q[touch_set];
  // A flushing touch never lands, so the lookup must not see it either.
  assign fwd        = touch_valid & ~flush & (touch_set == lookup_set);
  assign look_tree  = fwd ? touch_tree_next : tree_q[lookup_set];

  l2_plru_tree_logic #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W),
    .NODES    (NODES)
  ) u_tree_logic (
    .look_tree_i (look_tree),
    .way_valid_i (way_valid),
    .victim_o    (victim_way_d),
    .upd_tree_i  (touch_tree),
    .upd_way_i   (touch_way),
    .upd_tree_o  (touch_tree_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
      end else if (touch_valid) begin
        tree_q[touch_set] <= touch_tree_next;
      end
      victim_valid_q <= lookup_valid;
      if (lookup_valid) victim_way_q <= victim_way_d;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_l2_plru_tracker.sv
// Directed vector table for the 4-way/32-set tracker, hand-written reset sequences, and a
// randomised 8-way/16-set run against an independent heap-index model.
module tb_l2_plru_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // 4-way / 32-set instance
  logic       flush, lookup_valid, touch_valid;
  logic [4:0] lookup_set, touch_set;
  logic [3:0] way_valid;
  logic [1:0] touch_way;
  logic       victim_valid;
  logic [1:0] victim_way;

  // 8-way / 16-set instance
  logic       flush8, lookup_valid8, touch_valid8;
  logic [3:0] lookup_set8, touch_set8;
  logic [7:0] way_valid8;
  logic [2:0] touch_way8;
  logic       victim_valid8;
  logic [2:0] victim_way8;

  l2_plru_tracker #(.NUM_WAYS(4), .NUM_SETS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set), .way_valid(way_valid),
    .victim_valid(victim_valid), .victim_way(victim_way),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way)
  );

  l2_plru_tracker #(.NUM_WAYS(8), .NUM_SETS(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8),
    .lookup_valid(lookup_valid8), .lookup_set(lookup_set8), .way_valid(way_valid8),
    .victim_valid(victim_valid8), .victim_way(victim_way8),
    .touch_valid(touch_valid8), .touch_set(touch_set8), .touch_way(touch_way8)
  );

  typedef struct {
    logic       tv;
    logic [4:0] ts;
    logic [1:0] tw;
    logic       lv;
    logic [4:0] ls;
    logic [3:0] wv;
    logic       fl;
    logic       evv;
    logic [1:0] ew;
  } vec_t;

  vec_t vecs [25];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic tv, input logic [4:0] ts, input logic [1:0] tw,
                              input logic lv, input logic [4:0] ls, input logic [3:0] wv,
                              input logic fl, input logic evv, input logic [1:0] ew);
    vec_t v;
    v.tv = tv; v.ts = ts; v.tw = tw; v.lv = lv; v.ls = ls; v.wv = wv;
    v.fl = fl; v.evv = evv; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    flush = 0; lookup_valid = 0; touch_valid = 0;
    lookup_set = '0; touch_set = '0; touch_way = '0; way_valid = 4'hF;
  endtask

  // Independent 8-way model: level l nodes start at 2^l-1, offset by the way prefix.
  function automatic logic [6:0] m_upd(input logic [6:0] t, input int w);
    logic [6:0] r;
    logic [2:0] idx;
    r = t;
    for (int l = 0; l < 3; l++) begin
      idx    = 3'((1 << l) - 1 + (w >> (3 - l)));
      r[idx] = 1'((w >> (2 - l)) & 1);
    end
    return r;
  endfunction

  function automatic int m_vic(input logic [6:0] t, input logic [7:0] wv);
    int         p;
    logic [2:0] idx;
    for (int i = 0; i < 8; i++) if (!wv[i]) return i;
    p = 0;
    for (int l = 0; l < 3; l++) begin
      idx = 3'((1 << l) - 1 + p);
      p   = p * 2 + (t[idx] ? 0 : 1);
    end
    return p;
  endfunction

  logic [6:0] m8 [16];

  initial begin
    int         exp_way8;
    logic       exp_vv8;
    logic [6:0] lt;

    vecs[0]  = mk(0, 0, 0, 1, 0, 4'hF, 0, 1, 3);  // reset tree -> way3
    vecs[1]  = mk(1, 0, 3, 0, 0, 4'hF, 0, 0, 3);
    vecs[2]  = mk(0, 0, 0, 1, 0, 4'hF, 0, 1, 1);  // tree 101 -> way1
    vecs[3]  = mk(1, 4, 0, 0, 0, 4'hF, 0, 0, 1);
    vecs[4]  = mk(1, 4, 1, 0, 0, 4'hF, 0, 0, 1);
    vecs[5]  = mk(1, 4, 2, 0, 0, 4'hF, 0, 0, 1);
    vecs[6]  = mk(1, 4, 3, 0, 0, 4'hF, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 4, 4'hF, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 5, 4'hF, 0, 1, 3);
    vecs[9]  = mk(1, 2, 0, 0, 0, 4'hF, 0, 0, 3);
    vecs[10] = mk(0, 0, 0, 1, 2, 4'hB, 0, 1, 2);  // invalid way2
    vecs[11] = mk(0, 0, 0, 1, 0, 4'h6, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 4'h7, 0, 1, 3);
    vecs[13] = mk(1, 7, 3, 1, 7, 4'hF, 0, 1, 1);  // forwarded
    vecs[14] = mk(1, 8, 3, 1, 9, 4'hF, 0, 1, 3);  // different sets
    vecs[15] = mk(0, 0, 0, 0, 0, 4'hF, 0, 0, 3);
    vecs[16] = mk(1, 1, 3, 0, 0, 4'hF, 0, 0, 3);
    vecs[17] = mk(1, 2, 3, 0, 0, 4'hF, 0, 0, 3);
    vecs[18] = mk(1, 3, 3, 0, 0, 4'hF, 0, 0, 3);
    vecs[19] = mk(0, 0, 0, 1, 1, 4'hF, 0, 1, 1);
    vecs[20] = mk(1, 1, 0, 1, 1, 4'hF, 1, 1, 1);  // flush: pre-flush, touch ignored
    vecs[21] = mk(0, 0, 0, 1, 1, 4'hF, 0, 1, 3);
    vecs[22] = mk(0, 0, 0, 1, 2, 4'hF, 0, 1, 3);
    vecs[23] = mk(0, 0, 0, 1, 0, 4'h0, 0, 1, 0);
    vecs[24] = mk(0, 0, 0, 1, 7, 4'hF, 0, 1, 3);

    rst_n = 0;
    idle4();
    flush8 = 0; lookup_valid8 = 0; touch_valid8 = 0;
    lookup_set8 = '0; touch_set8 = '0; touch_way8 = '0; way_valid8 = 8'hFF;
    tick();
    tick();
    chk("reset_vv", 32'(victim_valid), 0);
    chk("reset_way", 32'(victim_way), 0);
    chk("reset_vv8", 32'(victim_valid8), 0);
    chk("reset_way8", 32'(victim_way8), 0);
    $display("reset: vv=%0d way=%0d", victim_valid, victim_way);
    rst_n = 1;

    for (int i = 0; i < 25; i++) begin
      touch_valid = vecs[i].tv; touch_set = vecs[i].ts; touch_way = vecs[i].tw;
      lookup_valid = vecs[i].lv; lookup_set = vecs[i].ls; way_valid = vecs[i].wv;
      flush = vecs[i].fl;
      tick();
      $display("vec %0d: vv=%0d way=%0d (exp %0d/%0d)", i, victim_valid, victim_way,
               vecs[i].evv, vecs[i].ew);
      chk($sformatf("vec%0d_vv", i), 32'(victim_valid), 32'(vecs[i].evv));
      chk($sformatf("vec%0d_way", i), 32'(victim_way), 32'(vecs[i].ew));
    end

    // Reset with a lookup in flight: no victim, state cleared.
    idle4();
    touch_valid = 1; touch_set = 10; touch_way = 3;
    tick();
    idle4();
    lookup_valid = 1; lookup_set = 10;
    tick();
    chk("pre_rst_way", 32'(victim_way), 1);
    $display("pre-reset lookup set10: vv=%0d way=%0d", victim_valid, victim_way);
    rst_n = 0;
    tick();
    chk("rst_lookup_vv", 32'(victim_valid), 0);
    chk("rst_lookup_way", 32'(victim_way), 0);
    $display("lookup under reset: vv=%0d way=%0d", victim_valid, victim_way);
    rst_n = 1;
    idle4();
    tick();
    chk("post_rst_vv", 32'(victim_valid), 0);
    lookup_valid = 1; lookup_set = 10;
    tick();
    chk("post_rst_way", 32'(victim_way), 3);
    chk("post_rst_vv1", 32'(victim_valid), 1);
    $display("post-reset lookup set10: vv=%0d way=%0d", victim_valid, victim_way);
    idle4();

    // Randomised 8-way run; sets kept narrow to exercise forwarding and flush overlap.
    for (int s = 0; s < 16; s++) m8[s] = '0;
    exp_way8 = 0;
    for (int c = 0; c < 400; c++) begin
      touch_valid8  = 1'($urandom_range(0, 1));
      touch_set8    = 4'($urandom_range(0, 3));
      touch_way8    = 3'($urandom_range(0, 7));
      lookup_valid8 = 1'($urandom_range(0, 1));
      lookup_set8   = 4'($urandom_range(0, 3));
      way_valid8    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      flush8        = ($urandom_range(0, 19) == 0);
      if (touch_valid8 && !flush8 && touch_set8 == lookup_set8)
        lt = m_upd(m8[touch_set8], int'(touch_way8));
      else
        lt = m8[lookup_set8];
      exp_vv8 = lookup_valid8;
      if (lookup_valid8) exp_way8 = m_vic(lt, way_valid8);
      if (flush8) for (int s = 0; s < 16; s++) m8[s] = '0;
      else if (touch_valid8) m8[touch_set8] = m_upd(m8[touch_set8], int'(touch_way8));
      tick();
      $display("rnd8 %0d: tv=%0d ts=%0d tw=%0d lv=%0d ls=%0d wv=%h fl=%0d -> vv=%0d way=%0d",
               c, touch_valid8, touch_set8, touch_way8, lookup_valid8, lookup_set8,
               way_valid8, flush8, victim_valid8, victim_way8);
      chk($sformatf("rnd8_%0d_vv", c), 32'(victim_valid8), 32'(exp_vv8));
      chk($sformatf("rnd8_%0d_way", c), 32'(victim_way8), 32'(exp_way8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
